// File: rtl/isa_pkg.sv
// isa_pkg: shared instruction field positions, bubble word, two-word predecode and fetch FSM states
package isa_pkg;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 14;
  localparam int FUNC_MSB = 13;
  localparam int FUNC_LSB = 11;
  localparam int RA_MSB = 10;
  localparam int RA_LSB = 8;
  localparam int RB_MSB = 7;
  localparam int RB_LSB = 5;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  typedef enum logic [1:0] {S_VEC, S_RUN, S_IMM} fetch_state_t;
  function automatic logic is_two_word(input logic [15:0] w);
    return w[15:13] == 3'b011;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and bubble-load controls
module if_id_reg #(
  parameter int PC_W = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [15:0]     d_instr,
  input  logic [15:0]     d_imm,
  input  logic [PC_W-1:0] d_pc_next,
  output logic            valid,
  output logic [15:0]     instr,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc_next
);
  // hold keeps contents, otherwise load either the bubble or the new instruction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid   <= 1'b0;
      instr   <= NOP_WORD;
      imm     <= '0;
      pc_next <= '0;
    end else if (!hold) begin
      valid   <= !flush;
      instr   <= flush ? NOP_WORD : d_instr;
      imm     <= flush ? '0 : d_imm;
      pc_next <= flush ? '0 : d_pc_next;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, reset-vector load and one/two-word instruction assembly feeding IF/ID
module fetch_stage
  import isa_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [15:0] NOP_WORD = isa_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  output logic [15:0]     if_instruction,
  output logic [15:0]     if_imm,
  output logic [PC_W-1:0] if_pc_next
);
  localparam logic [PC_W-1:0] ONE = 1;
  fetch_state_t state, state_d;
  logic [PC_W-1:0] pc, pc_d, pc_inc;
  logic [15:0] first_q, first_d, instr_d, imm_d;
  logic emit, hold, flush, live;
  // state, pc and pending opcode registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_VEC;
      pc      <= '0;
      first_q <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      first_q <= first_d;
    end
  // next state: normal sequencing, then redirect and stall override outside S_VEC
  always_comb begin
    pc_inc  = pc + ONE;
    state_d = state;
    pc_d    = pc_inc;
    first_d = first_q;
    emit    = 1'b0;
    instr_d = imem_data;
    imm_d   = '0;
    case (state)
      S_VEC: begin
        pc_d    = PC_W'(imem_data);
        state_d = S_RUN;
      end
      S_RUN: begin
        emit    = !is_two_word(imem_data);
        first_d = emit ? first_q : imem_data;
        state_d = emit ? S_RUN : S_IMM;
      end
      default: begin
        emit    = 1'b1;
        instr_d = first_q;
        imm_d   = imem_data;
        state_d = S_RUN;
      end
    endcase
    live = state != S_VEC;
    if (live && redirect) begin
      pc_d    = redirect_pc;
      state_d = S_RUN;
      first_d = '0;
      emit    = 1'b0;
    end else if (live && stall) begin
      pc_d    = pc;
      state_d = state;
      first_d = first_q;
    end
  end
  // outputs: fetch address from state/pc only, IF/ID hold and bubble controls
  always_comb begin
    imem_addr = state == S_VEC ? '0 : pc;
    hold      = live && stall && !redirect;
    flush     = !emit;
  end
  if_id_reg #(.PC_W(PC_W), .NOP_WORD(NOP_WORD)) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .flush     (flush),
    .d_instr   (instr_d),
    .d_imm     (imm_d),
    .d_pc_next (pc_inc),
    .valid     (if_valid),
    .instr     (if_instruction),
    .imm       (if_imm),
    .pc_next   (if_pc_next)
  );
endmodule
